// File: rtl/stream_mux_pkg.sv
//------------------------------------------------------------------------------
// Module  : stream_mux_pkg
// Brief   : Shared types and helpers for the round-robin stream multiplexer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stream_mux_pkg;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Brief   : Combinational rotating-priority arbiter, one-hot grant plus index.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              fixed,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_any
);

    logic [SEL_W-1:0]    start;
    logic [2*NUM_CH-1:0] dbl;
    logic [SEL_W-1:0]    offset;
    logic                found;
    logic [SEL_W:0]      sum;

    assign start = fixed ? '0 : ptr;
    // Rotating the doubled vector puts the start channel at bit 0.
    assign dbl   = {req, req} >> start;

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && dbl[i]) begin
                found  = 1'b1;
                offset = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= (SEL_W+1)'(NUM_CH)) begin
            sum = sum - (SEL_W+1)'(NUM_CH);
        end
    end

    assign grant_idx = sum[SEL_W-1:0];
    assign grant_any = found;
    assign grant     = found ? (NUM_CH'(1) << grant_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
//------------------------------------------------------------------------------
// Module  : stream_mux_rr
// Brief   : N-channel packet-aware valid/ready merge with registered output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode_fixed,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [SEL_W-1:0]  lock_ch, lock_nxt;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic              load_en;
    logic              accept;
    logic              beat_last;

    assign load_en = !out_valid || out_ready;

    // While locked only the packet owner may request; a gap idles the output.
    assign req = (state == ST_LOCK) ? (in_valid & (NUM_CH'(1) << lock_ch)) : in_valid;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .fixed     (mode_fixed),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign in_ready  = load_en ? grant : '0;
    assign accept    = load_en && grant_any;
    assign beat_last = in_last[grant_idx];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_ch;
        if (accept) begin
            if (beat_last) begin
                state_nxt = ST_ARB;
                ptr_nxt   = (grant_idx == SEL_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
            end else begin
                state_nxt = ST_LOCK;
                lock_nxt  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ARB;
            ptr     <= '0;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_ch <= lock_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= in_data[grant_idx*WIDTH +: WIDTH];
                out_last <= beat_last;
                out_sel  <= grant_idx;
            end
        end
    end

endmodule

`default_nettype wire
